// File: rtl/trap_collector.sv
// Commit-side exception collector: keeps the oldest excepting instruction in
// flight and hands its cause/tval to the trap unit when the ROB commits it.
module trap_collector #(
  parameter  int NUM_PORTS = 4,
  parameter  int ROB_SIZE  = 128,
  parameter  int TVAL_W    = 64,
  localparam int IW        = $clog2(ROB_SIZE),
  localparam int RW        = IW + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              i_report_vld,
  input  logic [NUM_PORTS-1:0][RW-1:0]      i_report_robIdx,
  input  logic [NUM_PORTS-1:0][15:0]        i_report_cause,
  input  logic [NUM_PORTS-1:0][TVAL_W-1:0]  i_report_tval,
  input  logic                              i_squash_vld,
  input  logic [RW-1:0]                     i_squash_robIdx,
  input  logic                              i_commit_vld,
  input  logic [RW-1:0]                     i_commit_robIdx,
  input  logic                              i_trap_ack,
  output logic                              o_pending,
  output logic [RW-1:0]                     o_pending_robIdx,
  output logic                              o_trap_vld,
  output logic [15:0]                       o_trap_cause,
  output logic [TVAL_W-1:0]                 o_trap_tval,
  output logic [RW-1:0]                     o_trap_robIdx
);

  typedef struct packed {
    logic [RW-1:0]     idx;
    logic [15:0]       cause;
    logic [TVAL_W-1:0] tval;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HOLD, DELIVER} state_t;

  // a older than b; the flipped MSB inverts the idx order across a wrap
  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[IW] == b[IW]) return a[IW-1:0] < b[IW-1:0];
    return a[IW-1:0] > b[IW-1:0];
  endfunction

  state_t               state;
  rec_t                 rec;
  rec_t                 best;
  logic                 best_vld;
  logic [NUM_PORTS-1:0] surv;
  logic                 rec_killed;
  logic                 commit_hit;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    assign surv[p] = i_report_vld[p] &&
                     !(i_squash_vld && older(i_squash_robIdx, i_report_robIdx[p]));
  end

  // strict-older replacement keeps the lowest port on robIdx ties
  always_comb begin
    best_vld = 1'b0;
    best     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (surv[p] && (!best_vld || older(i_report_robIdx[p], best.idx))) begin
        best_vld   = 1'b1;
        best.idx   = i_report_robIdx[p];
        best.cause = i_report_cause[p];
        best.tval  = i_report_tval[p];
      end
    end
  end

  assign rec_killed = i_squash_vld && older(i_squash_robIdx, rec.idx);
  assign commit_hit = i_commit_vld && (i_commit_robIdx == rec.idx);
  assign o_pending_robIdx = rec.idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rec           <= '0;
      o_pending     <= 1'b0;
      o_trap_vld    <= 1'b0;
      o_trap_cause  <= '0;
      o_trap_tval   <= '0;
      o_trap_robIdx <= '0;
    end else begin
      case (state)
        IDLE: if (best_vld) begin
          rec       <= best;
          o_pending <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (commit_hit) begin
            state         <= DELIVER;
            o_trap_vld    <= 1'b1;
            o_trap_cause  <= rec.cause;
            o_trap_tval   <= rec.tval;
            o_trap_robIdx <= rec.idx;
          end else if (best_vld && (rec_killed || older(best.idx, rec.idx))) begin
            rec <= best;
          end else if (rec_killed) begin
            rec       <= '0;
            o_pending <= 1'b0;
            state     <= IDLE;
          end
        end
        DELIVER: if (i_trap_ack) begin
          // the trap flushes everything, so no older report can be in flight
          rec           <= '0;
          o_pending     <= 1'b0;
          o_trap_vld    <= 1'b0;
          o_trap_cause  <= '0;
          o_trap_tval   <= '0;
          o_trap_robIdx <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_collector.sv
// Self-checking bench for trap_collector: directed plan steps followed by
// randomized traffic against a modular-distance age reference model.
module tb_trap_collector;
  localparam int NP = 4;
  localparam int RW = 8;
  localparam int TW = 64;

  logic                 clk, rst;
  logic [NP-1:0]        rv;
  logic [NP-1:0][RW-1:0] ridx;
  logic [NP-1:0][15:0]  rc;
  logic [NP-1:0][TW-1:0] rt;
  logic                 sq, cv, ack;
  logic [RW-1:0]        sqi, ci;
  logic                 o_pending, o_trap_vld;
  logic [RW-1:0]        o_pending_robIdx, o_trap_robIdx;
  logic [15:0]          o_trap_cause;
  logic [TW-1:0]        o_trap_tval;

  trap_collector #(.NUM_PORTS(NP), .ROB_SIZE(128), .TVAL_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_report_vld(rv), .i_report_robIdx(ridx), .i_report_cause(rc), .i_report_tval(rt),
    .i_squash_vld(sq), .i_squash_robIdx(sqi),
    .i_commit_vld(cv), .i_commit_robIdx(ci), .i_trap_ack(ack),
    .o_pending(o_pending), .o_pending_robIdx(o_pending_robIdx),
    .o_trap_vld(o_trap_vld), .o_trap_cause(o_trap_cause),
    .o_trap_tval(o_trap_tval), .o_trap_robIdx(o_trap_robIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: one held record plus a delivering flag
  bit        m_pend, m_dlv;
  bit [7:0]  m_idx;
  bit [15:0] m_cause;
  bit [63:0] m_tval;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a older than b iff b sits 1..127 slots after a on the 256-entry age ring
  function automatic bit older_m(input int a, input int b);
    int d;
    d = (b - a) & 255;
    return d >= 1 && d <= 127;
  endfunction

  task automatic clr();
    rv = '0; ridx = '0; rc = '0; rt = '0;
    sq = 1'b0; sqi = '0; cv = 1'b0; ci = '0; ack = 1'b0;
  endtask

  task automatic rpt(input int p, input int idx, input int cause, input logic [63:0] tval);
    rv[p] = 1'b1; ridx[p] = idx[7:0]; rc[p] = cause[15:0]; rt[p] = tval;
  endtask

  task automatic check_model();
    chk("pending", o_pending, m_pend);
    if (m_pend) chk("pending_idx", o_pending_robIdx, m_idx);
    chk("trap_vld", o_trap_vld, m_dlv);
    if (m_dlv) begin
      chk("trap_cause", o_trap_cause, m_cause);
      chk("trap_tval", o_trap_tval, m_tval);
      chk("trap_idx", o_trap_robIdx, m_idx);
    end
  endtask

  // advance the model on the current inputs, clock once, compare
  task automatic cycle();
    int best;
    bit killed;
    best = -1;
    if (m_dlv) begin
      if (ack) begin m_dlv = 0; m_pend = 0; end
    end else if (m_pend && cv && ci == m_idx) begin
      m_dlv = 1;
    end else begin
      for (int p = 0; p < NP; p++)
        if (rv[p] && !(sq && older_m(sqi, ridx[p])) &&
            (best < 0 || older_m(ridx[p], ridx[best]))) best = p;
      killed = m_pend && sq && older_m(sqi, m_idx);
      if (best >= 0 && (!m_pend || killed || older_m(ridx[best], m_idx))) begin
        m_pend = 1; m_idx = ridx[best]; m_cause = rc[best]; m_tval = rt[best];
      end else if (killed) begin
        m_pend = 0;
      end
    end
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pending"}, o_pending, 0);
    chk({tag, "_pidx"}, o_pending_robIdx, 0);
    chk({tag, "_vld"}, o_trap_vld, 0);
    chk({tag, "_cause"}, o_trap_cause, 0);
    chk({tag, "_tval"}, o_trap_tval, 0);
    chk({tag, "_tidx"}, o_trap_robIdx, 0);
  endtask

  initial begin
    int base;
    clr();
    rst = 1'b0;
    m_pend = 0; m_dlv = 0; m_idx = 0; m_cause = 0; m_tval = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // single report then commit
    rpt(0, 5, 2, 64'hdead); cycle();
    chk("t1_pidx", o_pending_robIdx, 8'd5);
    clr(); cv = 1; ci = 8'd5; cycle();
    chk("t1_cause", o_trap_cause, 16'd2);
    chk("t1_tval", o_trap_tval, 64'hdead);
    clr(); ack = 1; cycle();
    chk("t1_cleared", {o_trap_vld, o_pending}, 2'b00);

    // same-cycle reports, oldest wins; younger later report ignored
    clr(); rpt(1, 9, 5, 64'h9); rpt(3, 7, 13, 64'h7); cycle();
    chk("t2_pidx", o_pending_robIdx, 8'd7);
    clr(); rpt(0, 8, 6, 64'h8); cycle();
    chk("t2_keep", o_pending_robIdx, 8'd7);
    clr(); cv = 1; ci = 8'd7; cycle();
    chk("t2_cause", o_trap_cause, 16'd13);
    clr(); ack = 1; cycle();

    // wrap: {0,125} is older than {1,3}
    clr(); rpt(2, 128 + 3, 9, 64'h3); cycle();
    clr(); rpt(1, 125, 4, 64'h125); cycle();
    chk("t3_pidx", o_pending_robIdx, 8'd125);
    clr(); cv = 1; ci = 8'd125; cycle();
    chk("t3_cause", o_trap_cause, 16'd4);
    clr(); ack = 1; cycle();

    // squash replacing and clearing the record
    clr(); rpt(0, 40, 3, 64'h40); cycle();
    clr(); sq = 1; sqi = 8'd30; rpt(0, 20, 1, 64'h20); cycle();
    chk("t4_pidx", o_pending_robIdx, 8'd20);
    clr(); sq = 1; sqi = 8'd10; cycle();
    chk("t4_idle", o_pending, 1'b0);

    // DELIVER holds outputs while ack is withheld
    clr(); rpt(2, 50, 7, 64'h1234); cycle();
    clr(); cv = 1; ci = 8'd50; cycle();
    for (int k = 0; k < 5; k++) begin
      clr(); rpt(0, 45, 11, 64'h45); sq = 1; sqi = 8'd44; cv = 1; ci = 8'd45; cycle();
      chk("t5_cause", o_trap_cause, 16'd7);
      chk("t5_tval", o_trap_tval, 64'h1234);
      chk("t5_idx", o_trap_robIdx, 8'd50);
    end
    clr(); ack = 1; cycle();

    // asynchronous reset mid-DELIVER
    clr(); rpt(0, 60, 8, 64'h60); cycle();
    clr(); cv = 1; ci = 8'd60; cycle();
    chk("t6_vld", o_trap_vld, 1'b1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    m_pend = 0; m_dlv = 0;
    @(posedge clk); #3 rst = 1'b1;
    clr(); cv = 1; ci = 8'd60; cycle();
    chk("t6_notrap", o_trap_vld, 1'b0);

    // randomized traffic in a drifting age window (crosses the flip boundary)
    base = 100;
    for (int it = 0; it < 600; it++) begin
      clr();
      if (it % 40 == 0) base = (base + $urandom_range(0, 60)) & 255;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 9) < 3)
          rpt(p, (base + $urandom_range(0, 24)) & 255, $urandom_range(0, 65535),
              {$urandom, $urandom});
      if ($urandom_range(0, 9) == 0) begin
        sq = 1; sqi = 8'((base + $urandom_range(0, 24)) & 255);
      end
      if (m_pend && !m_dlv && $urandom_range(0, 3) == 0) begin
        cv = 1; ci = m_idx;
      end else if ($urandom_range(0, 9) == 0) begin
        cv = 1; ci = 8'((base + $urandom_range(0, 24)) & 255);
      end
      if (m_dlv && $urandom_range(0, 4) < 2) ack = 1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
